output_buffer: RTL

- Store-side companion of the switch/button input buffer in the single-cycle RISC-V core's memory-mapped I/O region.
- Captures CPU stores into output registers: red LEDs, green LEDs, eight 7-segment digits and the LCD.
- Drives the board pins from those registers.
- Returns register contents on loads.
- Includes a small LCD strobe sequencer, so one CPU store produces a correctly timed LCD EN pulse.

---
 rtl/output_buffer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/output_buffer.sv
// output_buffer: store-side memory-mapped output block of the RISC-V core.
// Captures CPU stores into LED, 7-segment and LCD registers, drives the board
// pins from them, returns register contents on loads, and sequences the LCD
// EN strobe so that one accepted LCD store yields one correctly timed pulse.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_st_en/i_addr/i_st_data/i_bmask   store strobe, address, lane-aligned data, byte mask
//   o_ld_data              combinational read data for i_addr
//   o_io_ledr, o_io_ledg   LED registers
//   o_io_hex0..7           active-low segment drive
//   o_io_lcd               [7:0] DATA, [8] RS, [9] RW, [10] EN, [31] ON
//   o_lcd_busy             high while the LCD sequencer is active
//
// Optional feature macro: OUTPUT_BUFFER_HEX_DECODE_EN
//   defined   : HEX byte [3:0] is a hex nibble decoded to segments, bit 4 blanks
//   undefined : HEX byte [6:0] drives the segments directly
module output_buffer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_st_en,
    input  logic [14:0] i_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_bmask,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    output logic        o_lcd_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
    localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Bits that physically exist in the HEX and LCD registers.
    localparam logic [31:0] HEX_KEEP = 32'h7F7F_7F7F;
    localparam logic [31:0] LCD_KEEP = 32'h8000_03FF;
`ifdef OUTPUT_BUFFER_HEX_DECODE_EN
    // Bit 4 set in every byte so the display comes out of reset blank.
    localparam logic [31:0] HEX_RST = 32'h1010_1010;
`else
    localparam logic [31:0] HEX_RST = 32'h7F7F_7F7F;
`endif

    logic [31:0]   ledr_r, ledg_r, hexlo_r, hexhi_r, lcd_r;
    logic          ovr_r, en_r, busy_r;
    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    sel_s;
    logic [31:0]   wmask_s;
    logic          lcd_st_s, accept_s;
    logic          unused_s;

    assign sel_s    = i_addr[14:12];
    assign wmask_s  = {{8{i_bmask[3]}}, {8{i_bmask[2]}}, {8{i_bmask[1]}}, {8{i_bmask[0]}}};
    assign lcd_st_s = i_st_en && (sel_s == 3'd4);
    assign accept_s = lcd_st_s && (state_r == ST_IDLE);
    // Word-internal address bits and byte offset carry no information here.
    assign unused_s = ^i_addr[11:0];

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] m);
        merge = (old_v & ~m) | (new_v & m);
    endfunction

    function automatic logic [6:0] seg_drive(input logic [7:0] b);
`ifdef OUTPUT_BUFFER_HEX_DECODE_EN
        if (b[4]) begin
            seg_drive = 7'h7F;
        end else begin
            case (b[3:0])
                4'h0: seg_drive = 7'h40;  4'h1: seg_drive = 7'h79;
                4'h2: seg_drive = 7'h24;  4'h3: seg_drive = 7'h30;
                4'h4: seg_drive = 7'h19;  4'h5: seg_drive = 7'h12;
                4'h6: seg_drive = 7'h02;  4'h7: seg_drive = 7'h78;
                4'h8: seg_drive = 7'h00;  4'h9: seg_drive = 7'h10;
                4'hA: seg_drive = 7'h08;  4'hB: seg_drive = 7'h03;
                4'hC: seg_drive = 7'h46;  4'hD: seg_drive = 7'h21;
                4'hE: seg_drive = 7'h06;  4'hF: seg_drive = 7'h0E;
                default: seg_drive = 7'h7F;
            endcase
        end
`else
        seg_drive = b[6:0];
`endif
    endfunction

    // LED and HEX registers: byte-masked store capture, never blocked by the LCD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr_r  <= 32'h0;
            ledg_r  <= 32'h0;
            hexlo_r <= HEX_RST;
            hexhi_r <= HEX_RST;
        end else if (i_st_en) begin
            case (sel_s)
                3'd0:    ledr_r  <= merge(ledr_r, i_st_data, wmask_s);
                3'd1:    ledg_r  <= merge(ledg_r, i_st_data, wmask_s);
                3'd2:    hexlo_r <= merge(hexlo_r, i_st_data, wmask_s) & HEX_KEEP;
                3'd3:    hexhi_r <= merge(hexhi_r, i_st_data, wmask_s) & HEX_KEEP;
                default: ledr_r  <= ledr_r;
            endcase
        end else begin
            ledr_r <= ledr_r;
        end
    end

    // LCD register and sticky overrun flag: stores only land while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lcd_r <= 32'h0;
            ovr_r <= 1'b0;
        end else if (accept_s) begin
            lcd_r <= merge(lcd_r, i_st_data, wmask_s) & LCD_KEEP;
            ovr_r <= i_bmask[3] ? 1'b0 : ovr_r;
        end else if (lcd_st_s) begin
            ovr_r <= 1'b1;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    // Strobe sequencer; EN and busy are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_SETUP;
                        cnt_r   <= CW'(T_SETUP - 1);
                        busy_r  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_PULSE;
                        cnt_r   <= CW'(T_PULSE - 1);
                        en_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= CW'(T_HOLD - 1);
                        en_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    en_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Load path: unmasked register readback, unmapped slots read zero.
    always_comb begin
        o_ld_data = 32'h0;
        case (sel_s)
            3'd0:    o_ld_data = ledr_r;
            3'd1:    o_ld_data = ledg_r;
            3'd2:    o_ld_data = hexlo_r;
            3'd3:    o_ld_data = hexhi_r;
            3'd4:    o_ld_data = lcd_r | {1'b0, ovr_r, 30'h0};
            default: o_ld_data = 32'h0;
        endcase
    end

    assign o_io_ledr  = ledr_r;
    assign o_io_ledg  = ledg_r;
    assign o_io_hex0  = seg_drive(hexlo_r[7:0]);
    assign o_io_hex1  = seg_drive(hexlo_r[15:8]);
    assign o_io_hex2  = seg_drive(hexlo_r[23:16]);
    assign o_io_hex3  = seg_drive(hexlo_r[31:24]);
    assign o_io_hex4  = seg_drive(hexhi_r[7:0]);
    assign o_io_hex5  = seg_drive(hexhi_r[15:8]);
    assign o_io_hex6  = seg_drive(hexhi_r[23:16]);
    assign o_io_hex7  = seg_drive(hexhi_r[31:24]);
    assign o_io_lcd   = lcd_r | {21'h0, en_r, 10'h0};
    assign o_lcd_busy = busy_r;

endmodule
